// File: rtl/barrel_shifter_pipe_amisha_pkg.sv
// Shared definitions for the pipelined barrel shifter: mode encodings and mode width.
package barrel_pkg_amisha;

    localparam int MODE_W = 3;

    // Encodings 5..7 are reserved; the datapath treats them as rotate-right.
    typedef enum logic [MODE_W-1:0] {
        MODE_ROR = 3'd0,
        MODE_ROL = 3'd1,
        MODE_SRL = 3'd2,
        MODE_SLL = 3'd3,
        MODE_SRA = 3'd4
    } mode_e;

endpackage

// File: rtl/barrel_shifter_pipe_amisha_stage.sv
// One registered barrel-shifter stage: shifts by SHIFT when its amount bit is set,
// and registers the result together with valid, amount, mode and carried sign.
module barrel_stage_amisha
    import barrel_pkg_amisha::*;
#(
    parameter  int WIDTH = 8,
    parameter  int SHIFT = 1,
    localparam int AMT_W = $clog2(WIDTH)
) (
    input  logic              clk_amisha,
    input  logic              reset_amisha,
    input  logic              i_en,
    input  logic              i_valid,
    input  logic [WIDTH-1:0]  i_data,
    input  logic [AMT_W-1:0]  i_amt,
    input  logic [MODE_W-1:0] i_mode,
    input  logic              i_sign,
    output logic              o_valid,
    output logic [WIDTH-1:0]  o_data,
    output logic [AMT_W-1:0]  o_amt,
    output logic [MODE_W-1:0] o_mode,
    output logic              o_sign
);

    localparam int BIT = $clog2(SHIFT);

    logic [WIDTH-1:0]  w_fill;
    logic [WIDTH-1:0]  w_shifted;
    logic [WIDTH-1:0]  w_next;

    logic              r_valid;
    logic [WIDTH-1:0]  r_data;
    logic [AMT_W-1:0]  r_amt;
    logic [MODE_W-1:0] r_mode;
    logic              r_sign;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
        w_fill    = i_sign ? ~({WIDTH{1'b1}} >> SHIFT) : '0;
        w_shifted = (i_data >> SHIFT) | (i_data << (WIDTH - SHIFT));
        case (i_mode)
            MODE_ROL: w_shifted = (i_data << SHIFT) | (i_data >> (WIDTH - SHIFT));
            MODE_SRL: w_shifted = i_data >> SHIFT;
            MODE_SLL: w_shifted = i_data << SHIFT;
            MODE_SRA: w_shifted = (i_data >> SHIFT) | w_fill;
            default:  ;
        endcase
    end

    assign w_next = i_amt[BIT] ? w_shifted : i_data;

    // NOTE: non-blocking assignments so every stage samples its predecessor's pre-edge value.
    always_ff @(posedge clk_amisha) begin
        if (reset_amisha) begin
            // NOTE: data/amt/mode are cleared too, so a reset pipe presents all-zero outputs.
            r_valid <= 1'b0;
            r_data  <= '0;
            r_amt   <= '0;
            r_mode  <= '0;
            r_sign  <= 1'b0;
        end else if (i_en) begin
            r_valid <= i_valid;
            r_data  <= w_next;
            r_amt   <= i_amt;
            r_mode  <= i_mode;
            r_sign  <= i_sign;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_amt   = r_amt;
    assign o_mode  = r_mode;
    assign o_sign  = r_sign;

endmodule

// File: rtl/barrel_shifter_pipe_amisha.sv
// Pipelined multi-mode barrel shifter: one registered stage per amount bit, with a
// single global advance so a downstream stall freezes the whole pipe.
module barrel_shifter_pipe_amisha
    import barrel_pkg_amisha::*;
#(
    parameter  int WIDTH = 8,
    localparam int AMT_W = $clog2(WIDTH)
) (
    input  logic              clk_amisha,
    input  logic              reset_amisha,
    input  logic              in_valid_amisha,
    output logic              in_ready_amisha,
    input  logic [WIDTH-1:0]  in_data_amisha,
    input  logic [AMT_W-1:0]  in_amt_amisha,
    input  logic [MODE_W-1:0] in_mode_amisha,
    output logic              out_valid_amisha,
    input  logic              out_ready_amisha,
    output logic [WIDTH-1:0]  out_data_amisha,
    output logic [MODE_W-1:0] out_mode_amisha
);

    // Index k is the input of stage k; index AMT_W is the last stage's output.
    logic              w_valid [0:AMT_W];
    logic [WIDTH-1:0]  w_data  [0:AMT_W];
    logic [AMT_W-1:0]  w_amt   [0:AMT_W];
    logic [MODE_W-1:0] w_mode  [0:AMT_W];
    logic              w_sign  [0:AMT_W];
    logic              w_adv;
    logic              w_unused_tail;

    assign w_adv = ~out_valid_amisha | out_ready_amisha;

    assign w_valid[0] = in_valid_amisha;
    assign w_data[0]  = in_data_amisha;
    assign w_amt[0]   = in_amt_amisha;
    assign w_mode[0]  = in_mode_amisha;
    assign w_sign[0]  = in_data_amisha[WIDTH-1];

    for (genvar k = 0; k < AMT_W; k++) begin : g_stage
        barrel_stage_amisha #(
            .WIDTH (WIDTH),
            .SHIFT (1 << k)
        ) u_stage (
            .clk_amisha   (clk_amisha),
            .reset_amisha (reset_amisha),
            .i_en         (w_adv),
            .i_valid      (w_valid[k]),
            .i_data       (w_data[k]),
            .i_amt        (w_amt[k]),
            .i_mode       (w_mode[k]),
            .i_sign       (w_sign[k]),
            .o_valid      (w_valid[k+1]),
            .o_data       (w_data[k+1]),
            .o_amt        (w_amt[k+1]),
            .o_mode       (w_mode[k+1]),
            .o_sign       (w_sign[k+1])
        );
    end

    // The amount and sign leaving the last stage have no consumer.
    assign w_unused_tail = ^{w_amt[AMT_W], w_sign[AMT_W]};

    assign in_ready_amisha  = w_adv;
    assign out_valid_amisha = w_valid[AMT_W];
    assign out_data_amisha  = w_data[AMT_W];
    assign out_mode_amisha  = w_mode[AMT_W];

endmodule

// File: tb/tb_barrel_shifter_pipe_amisha.sv
// Directed bench for the pipelined barrel shifter (8-bit and 32-bit builds).
module tb_barrel_shifter_pipe_amisha;
    import barrel_pkg_amisha::*;

    typedef struct {
        logic [31:0] d;
        logic [2:0]  m;
    } res32_t;

    logic        clk = 1'b0;
    logic        rst;
    int          checks = 0;
    int          failures = 0;

    logic        iv8, ir8, ov8, ordy8;
    logic [7:0]  id8, od8;
    logic [2:0]  ia8;
    logic [2:0]  im8, om8;

    logic        iv32, ir32, ov32, ordy32;
    logic [31:0] id32, od32;
    logic [4:0]  ia32;
    logic [2:0]  im32, om32;

    always #5 clk = ~clk;

    barrel_shifter_pipe_amisha #(.WIDTH(8)) dut8 (
        .clk_amisha       (clk),
        .reset_amisha     (rst),
        .in_valid_amisha  (iv8),
        .in_ready_amisha  (ir8),
        .in_data_amisha   (id8),
        .in_amt_amisha    (ia8),
        .in_mode_amisha   (im8),
        .out_valid_amisha (ov8),
        .out_ready_amisha (ordy8),
        .out_data_amisha  (od8),
        .out_mode_amisha  (om8)
    );

    barrel_shifter_pipe_amisha #(.WIDTH(32)) dut32 (
        .clk_amisha       (clk),
        .reset_amisha     (rst),
        .in_valid_amisha  (iv32),
        .in_ready_amisha  (ir32),
        .in_data_amisha   (id32),
        .in_amt_amisha    (ia32),
        .in_mode_amisha   (im32),
        .out_valid_amisha (ov32),
        .out_ready_amisha (ordy32),
        .out_data_amisha  (od32),
        .out_mode_amisha  (om32)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    function automatic logic [31:0] ref32(input logic [31:0] d, input logic [4:0] a,
                                          input logic [2:0] m);
        logic [63:0] t;
        case (m)
            3'd1: begin t = {d, d} << a; ref32 = t[63:32]; end
            3'd2: ref32 = d >> a;
            3'd3: ref32 = d << a;
            3'd4: ref32 = $unsigned($signed(d) >>> a);
            default: begin t = {d, d} >> a; ref32 = t[31:0]; end
        endcase
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        iv8 = 1'b1; id8 = 8'hFF; ia8 = 3'd3; im8 = 3'd4; ordy8 = 1'b1;
        iv32 = 1'b1; id32 = 32'hFFFF_FFFF; ia32 = 5'd7; im32 = 3'd4; ordy32 = 1'b1;
        repeat (3) step();
        rst = 1'b0; iv8 = 1'b0; iv32 = 1'b0;
        for (int c = 0; c < 5; c++) begin
            sample();
            checks++;
            if (ov8 !== 1'b0 || ov32 !== 1'b0)
                $display("FAIL reset_valid[%0d]: got %b/%b expected 0/0", c, ov8, ov32);
            if (ov8 !== 1'b0 || ov32 !== 1'b0) failures++;
            checks++;
            if (ir8 !== 1'b1 || ir32 !== 1'b1) begin
                $display("FAIL reset_ready[%0d]: got %b/%b expected 1/1", c, ir8, ir32);
                failures++;
            end
            if (c == 0) begin
                checks++;
                if (od8 !== 8'h00 || om8 !== 3'd0 || od32 !== 32'h0 || om32 !== 3'd0) begin
                    $display("FAIL reset_outputs: got %h/%0d %h/%0d expected zero", od8, om8, od32, om32);
                    failures++;
                end
            end
            step();
        end
    endtask

    task automatic test_modes();
        logic [7:0] exp_d [0:4] = '{8'hD2, 8'hB4, 8'h25, 8'hB0, 8'hE5};
        logic [2:0] md    [0:4] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
        logic [2:0] am    [0:4] = '{3'd3, 3'd3, 3'd2, 3'd3, 3'd2};
        for (int n = 0; n < 8; n++) begin
            ordy8 = 1'b1;
            if (n < 5) begin
                iv8 = 1'b1; id8 = 8'h96; ia8 = am[n]; im8 = md[n];
            end else begin
                iv8 = 1'b0;
            end
            sample();
            checks++;
            if (ir8 !== 1'b1) begin
                $display("FAIL modes_ready[%0d]: got %b expected 1", n, ir8);
                failures++;
            end
            checks++;
            if (n >= 3) begin
                if (ov8 !== 1'b1 || od8 !== exp_d[n-3] || om8 !== md[n-3]) begin
                    $display("FAIL modes_result[%0d]: got v=%b d=%h m=%0d expected v=1 d=%h m=%0d",
                             n - 3, ov8, od8, om8, exp_d[n-3], md[n-3]);
                    failures++;
                end
            end else if (ov8 !== 1'b0) begin
                $display("FAIL modes_latency[%0d]: got valid %b expected 0", n, ov8);
                failures++;
            end
            step();
        end
    endtask

    task automatic test_amt_zero();
        logic [2:0] md    [0:8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd6};
        logic [2:0] am    [0:8] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1};
        logic [7:0] dat   [0:8] = '{8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h01};
        logic [7:0] exp_d [0:8] = '{8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h80};
        for (int n = 0; n < 12; n++) begin
            ordy8 = 1'b1;
            if (n < 9) begin
                iv8 = 1'b1; id8 = dat[n]; ia8 = am[n]; im8 = md[n];
            end else begin
                iv8 = 1'b0;
            end
            sample();
            if (n >= 3) begin
                checks++;
                if (ov8 !== 1'b1 || od8 !== exp_d[n-3] || om8 !== md[n-3]) begin
                    $display("FAIL amt0_result[%0d]: got v=%b d=%h m=%0d expected v=1 d=%h m=%0d",
                             n - 3, ov8, od8, om8, exp_d[n-3], md[n-3]);
                    failures++;
                end
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] dat   [0:7] = '{8'h01, 8'h80, 8'hFF, 8'hFF, 8'h80, 8'h7F, 8'h3C, 8'h81};
        logic [2:0] am    [0:7] = '{3'd1, 3'd1, 3'd7, 3'd7, 3'd7, 3'd4, 3'd4, 3'd5};
        logic [2:0] md    [0:7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd1, 3'd0};
        logic [7:0] exp_d [0:7] = '{8'h80, 8'h01, 8'h01, 8'h80, 8'hFF, 8'h07, 8'hC3, 8'h0C};
        int nxt = 0;
        int out_idx = 0;
        logic stall, exp_ov;
        for (int c = 0; c < 18; c++) begin
            stall  = (c >= 5 && c <= 8);
            exp_ov = (c >= 3 && c <= 14);
            ordy8  = ~stall;
            if (nxt < 8) begin
                iv8 = 1'b1; id8 = dat[nxt]; ia8 = am[nxt]; im8 = md[nxt];
            end else begin
                iv8 = 1'b0;
            end
            sample();
            checks++;
            if (ir8 !== ~stall) begin
                $display("FAIL bp_ready[%0d]: got %b expected %b", c, ir8, ~stall);
                failures++;
            end
            checks++;
            if (ov8 !== exp_ov) begin
                $display("FAIL bp_valid[%0d]: got %b expected %b", c, ov8, exp_ov);
                failures++;
            end
            if (ov8 === 1'b1 && out_idx < 8) begin
                checks++;
                if (od8 !== exp_d[out_idx] || om8 !== md[out_idx]) begin
                    $display("FAIL bp_result[%0d] cycle %0d: got d=%h m=%0d expected d=%h m=%0d",
                             out_idx, c, od8, om8, exp_d[out_idx], md[out_idx]);
                    failures++;
                end
            end
            if (ov8 === 1'b1 && ordy8) out_idx++;
            if (iv8 && ir8 === 1'b1) nxt++;
            step();
        end
        checks++;
        if (out_idx != 8 || nxt != 8) begin
            $display("FAIL bp_count: got out=%0d in=%0d expected 8/8", out_idx, nxt);
            failures++;
        end
    endtask

    task automatic test_reset_midflight();
        ordy8 = 1'b0;
        for (int c = 0; c < 3; c++) begin
            iv8 = 1'b1; id8 = 8'h41 + 8'(c); ia8 = 3'd1; im8 = 3'd3;
            step();
        end
        iv8 = 1'b0;
        rst = 1'b1;
        sample();
        checks++;
        if (ov8 !== 1'b1 || od8 !== 8'h82 || ir8 !== 1'b0) begin
            $display("FAIL midreset_stalled: got v=%b d=%h r=%b expected v=1 d=82 r=0", ov8, od8, ir8);
            failures++;
        end
        step();
        rst = 1'b0;
        sample();
        checks++;
        if (ov8 !== 1'b0 || od8 !== 8'h00 || om8 !== 3'd0 || ir8 !== 1'b1) begin
            $display("FAIL midreset_after: got v=%b d=%h m=%0d r=%b expected v=0 d=00 m=0 r=1",
                     ov8, od8, om8, ir8);
            failures++;
        end
        step();
        ordy8 = 1'b1;
        for (int c = 0; c < 4; c++) begin
            sample();
            checks++;
            if (ov8 !== 1'b0) begin
                $display("FAIL midreset_flushed[%0d]: got valid %b expected 0", c, ov8);
                failures++;
            end
            step();
        end
    endtask

    task automatic test_w32_latency();
        ordy32 = 1'b1;
        for (int c = 0; c < 8; c++) begin
            iv32 = (c == 0); id32 = 32'h8000_0000; ia32 = 5'd31; im32 = 3'd4;
            sample();
            checks++;
            if (ov32 !== (c == 5)) begin
                $display("FAIL w32_latency[%0d]: got valid %b expected %b", c, ov32, (c == 5));
                failures++;
            end
            if (c == 5) begin
                checks++;
                if (od32 !== 32'hFFFF_FFFF || om32 !== 3'd4) begin
                    $display("FAIL w32_sra31: got d=%h m=%0d expected d=ffffffff m=4", od32, om32);
                    failures++;
                end
            end
            step();
        end
    endtask

    task automatic test_w32_random();
        localparam int N_OPS = 10000;
        res32_t q[$];
        res32_t r;
        int sent = 0;
        int cyc = 0;
        while ((sent < N_OPS || q.size() > 0) && cyc < 40000) begin
            ordy32 = ($urandom_range(0, 3) != 0);
            if (sent < N_OPS) begin
                iv32 = ($urandom_range(0, 7) != 0);
                id32 = $urandom();
                ia32 = 5'($urandom_range(0, 31));
                im32 = 3'($urandom_range(0, 7));
            end else begin
                iv32 = 1'b0;
            end
            sample();
            if (ov32 === 1'b1 && ordy32) begin
                checks++;
                if (q.size() == 0) begin
                    $display("FAIL w32_extra: unexpected result d=%h at cycle %0d", od32, cyc);
                    failures++;
                end else begin
                    r = q.pop_front();
                    if (od32 !== r.d || om32 !== r.m) begin
                        $display("FAIL w32_result cycle %0d: got d=%h m=%0d expected d=%h m=%0d",
                                 cyc, od32, om32, r.d, r.m);
                        failures++;
                    end
                end
            end
            if (iv32 && ir32 === 1'b1) begin
                r.d = ref32(id32, ia32, im32);
                r.m = im32;
                q.push_back(r);
                sent++;
            end
            cyc++;
            step();
        end
        iv32 = 1'b0;
        checks++;
        if (sent != N_OPS || q.size() != 0) begin
            $display("FAIL w32_drain: got sent=%0d pending=%0d expected %0d/0", sent, q.size(), N_OPS);
            failures++;
        end
    endtask

    initial begin
        rst = 1'b1;
        iv8 = 1'b0; id8 = '0; ia8 = '0; im8 = '0; ordy8 = 1'b1;
        iv32 = 1'b0; id32 = '0; ia32 = '0; im32 = '0; ordy32 = 1'b1;
        step();
        test_reset();
        test_modes();
        test_amt_zero();
        test_backpressure();
        test_reset_midflight();
        test_w32_latency();
        test_w32_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/barrel_shifter_pipe_amisha.md
# barrel_shifter_pipe_amisha

Parametrised, pipelined, multi-mode barrel shifter: the successor to the team's fixed 8-bit rotate-right stage shifter. It accepts one WIDTH-bit operand per cycle through a valid/ready handshake and applies one of five shift/rotate modes by a run-time amount. One register stage sits per log2(WIDTH) shift stage, so results emerge after a fixed latency with full backpressure support. It sits between datapath producers (ALU operand muxes) and consumers that can stall.

## Interface
- WIDTH, default 8: data width; must be a power of two, ≥ 2.
- AMT_W, default $clog2(WIDTH): shift-amount width; derived, not overridden.
- clk_amisha  in  1  rising-edge clock.
- reset_amisha  in  1  synchronous, active-high reset.
- in_valid_amisha  in  1  input operand valid.
- in_ready_amisha  out  1  block can accept input this cycle.
- in_data_amisha  in  WIDTH  operand.
- in_amt_amisha  in  AMT_W  shift amount, 0..WIDTH-1.
- in_mode_amisha  in  3  0=ROR, 1=ROL, 2=SRL, 3=SLL, 4=SRA; 5..7 reserved, treated as ROR.
- out_valid_amisha  out  1  result valid.
- out_ready_amisha  in  1  downstream accepts result.
- out_data_amisha  out  WIDTH  shifted result.
- out_mode_amisha  out  3  mode that produced out_data (debug/sideband).

## Operation
- Stage k (k = 0..AMT_W-1) shifts by 2^k when amt bit k is set; otherwise it passes data unchanged. Each stage's output is registered together with its valid bit, the remaining amt bits, and the mode.
- ROR: bits leaving the LSB enter at the MSB. ROL: the mirror of ROR.
- SRL: zero fill at the MSB. SLL: zero fill at the LSB.
- SRA: the original operand MSB fills at the MSB. Stage 0 captures the sign bit and carries it down the pipe.
- Amount 0, any mode: output equals input.
- Pipeline advance: adv = ~out_valid_amisha | out_ready_amisha.
  - in_ready_amisha = adv (combinational).
  - When adv=1, every stage loads from its predecessor, and stage 0 loads in_*. Stage 0 valid = in_valid_amisha.
  - When adv=0, all stages hold.
- Bubbles are not compressed; a stall freezes the whole pipe.
- A transfer occurs on a cycle with valid & ready high on the respective side. Results leave in input order; none are dropped or duplicated.

## Timing
- Latency: AMT_W cycles from input acceptance to out_valid_amisha, with no stalls (WIDTH=8 gives 3 cycles).
- Throughput: one operation per cycle while out_ready_amisha=1.
- Reset (synchronous): all stage valid bits, data, amt and mode registers clear to 0.
  - out_valid_amisha=0, out_data_amisha=0, out_mode_amisha=0.
  - in_ready_amisha=1 from the first cycle after reset.
- Reset mid-operation: all in-flight operations are discarded; no output fires in the cycle after reset deasserts.
- Simultaneous in_valid and reset: the input is ignored.
- out_valid_amisha high with out_ready_amisha low: out_data_amisha and out_mode_amisha stay stable until the transfer.
- No combinational path from in_data_amisha to out_data_amisha. The only combinational path is out_ready_amisha → in_ready_amisha.

## Structure
- Shared package barrel_pkg_amisha holds the mode encodings (MODE_ROR, MODE_ROL, MODE_SRL, MODE_SLL, MODE_SRA) and the mode width constant.
- Sub-module barrel_stage_amisha: one registered stage, parameterised by WIDTH and SHIFT (2^k).
  - Ports: enable, in valid/data/amt/mode/sign, out registered equivalents.
  - The top uses a generate loop over k.

## Test plan
- WIDTH=8, data 0x96, out_ready held 1, one operation per mode in consecutive cycles:
  - ROR amt 3 → 0xD2
  - ROL amt 3 → 0xB4
  - SRL amt 2 → 0x25
  - SLL amt 3 → 0xB0
  - SRA amt 2 → 0xE5
  - Each result appears 3 cycles after acceptance, back-to-back.
- Amount 0 for every mode with data 0xA5 → 0xA5 in all cases. Mode 6, amt 1, data 0x01 → 0x80.
- Backpressure: stream 8 operations, drop out_ready for 4 cycles mid-stream.
  - in_ready falls in the same cycle.
  - Outputs hold stable during the stall.
  - All 8 results arrive in order with no loss.
- Reset with 3 operations in flight → out_valid stays 0 afterwards. out_data=0, in_ready=1 the cycle after reset.
- WIDTH=32 build, random data/amt/mode, 10k operations → matches reference model with latency 5. SRA 0x8000_0000 amt 31 → 0xFFFF_FFFF.
